// File: rtl/sw_debounce.sv
// Per-bit 2-FF synchroniser + counter debouncer for raw switch inputs; level accepted DEBOUNCE_CYCLES+1 edges after first sample.
// No backpressure: outputs are free-running registered levels and one-cycle edge pulses.
module sw_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int CNT_W           = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]            s1_q, s1_d;
  logic [WIDTH-1:0]            s2_q, s2_d;
  logic [WIDTH-1:0]            sw_db_q, sw_db_d;
  logic [WIDTH-1:0]            sw_rise_q, sw_rise_d;
  logic [WIDTH-1:0]            sw_fall_q, sw_fall_d;
  logic                        sw_changed_q, sw_changed_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d      = sw_in;
    s2_d      = s1_q;
    sw_db_d   = sw_db_q;
    sw_rise_d = '0;
    sw_fall_d = '0;
    cnt_d     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      // Counter only runs while the synchronised level disagrees with the accepted one;
      // any agreement (glitch back) leaves it at zero.
      if (s2_q[i] != sw_db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          sw_db_d[i]   = s2_q[i];
          sw_rise_d[i] = s2_q[i];
          sw_fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    sw_changed_d = |(sw_rise_d | sw_fall_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q         <= '0;
      s2_q         <= '0;
      sw_db_q      <= '0;
      sw_rise_q    <= '0;
      sw_fall_q    <= '0;
      sw_changed_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      sw_db_q      <= sw_db_d;
      sw_rise_q    <= sw_rise_d;
      sw_fall_q    <= sw_fall_d;
      sw_changed_q <= sw_changed_d;
      cnt_q        <= cnt_d;
    end
  end

  assign sw_db      = sw_db_q;
  assign sw_rise    = sw_rise_q;
  assign sw_fall    = sw_fall_q;
  assign sw_changed = sw_changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with WIDTH=4, DEBOUNCE_CYCLES=8.
module tb_sw_debounce;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_in;
  logic [3:0] sw_db;
  logic [3:0] sw_rise;
  logic [3:0] sw_fall;
  logic       sw_changed;

  int checks;
  int errors;

  sw_debounce #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(8),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw_in(sw_in),
    .sw_db(sw_db),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .sw_changed(sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] db, input logic [3:0] r,
                         input logic [3:0] f, input logic c);
    chk({tag, ".db"},   32'(sw_db),      32'(db));
    chk({tag, ".rise"}, 32'(sw_rise),    32'(r));
    chk({tag, ".fall"}, 32'(sw_fall),    32'(f));
    chk({tag, ".chg"},  32'(sw_changed), 32'(c));
  endtask

  // Step n-1 edges expecting the old level held with no pulses, then check
  // the acceptance edge (the n-th after the new level is first sampled).
  task automatic expect_accept(input string tag, input int n, input logic [3:0] old_db,
                               input logic [3:0] new_db, input logic [3:0] r, input logic [3:0] f);
    for (int k = 1; k < n; k++) begin
      tick();
      chk_all({tag, ".hold"}, old_db, 4'b0, 4'b0, 1'b0);
    end
    tick();
    chk_all({tag, ".acc"}, new_db, r, f, 1'b1);
    tick();
    chk_all({tag, ".post"}, new_db, 4'b0, 4'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int pulses;
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    sw_in  = 4'b1111;
    #1 rst_n = 1'b0;
    #1;
    chk_all("reset", 4'b0, 4'b0, 4'b0, 1'b0);
    tick();
    tick();
    chk_all("reset_clk", 4'b0, 4'b0, 4'b0, 1'b0);

    // Power-up high: release between edges, next edge is E0, accept at E0+9.
    rst_n = 1'b1;
    expect_accept("pwrup", 10, 4'b0000, 4'b1111, 4'b1111, 4'b0000);

    // All low so bit0 starts at 0.
    sw_in = 4'b0000;
    expect_accept("all_low", 10, 4'b1111, 4'b0000, 4'b0000, 4'b1111);

    // 7-cycle raw high on bit0: rejected.
    sw_in  = 4'b0001;
    pulses = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (sw_changed) pulses++;
    end
    sw_in = 4'b0000;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (sw_changed || sw_db != 4'b0) pulses++;
    end
    chk("glitch7", 32'(pulses), 32'd0);
    chk("glitch7.db", 32'(sw_db), 32'd0);

    // 8-cycle raw high on bit0 (held): accepted at first-sample+9.
    sw_in = 4'b0001;
    expect_accept("glitch8", 10, 4'b0000, 4'b0001, 4'b0001, 4'b0000);

    // Raise bit3 so it can bounce down.
    sw_in = 4'b1001;
    expect_accept("b3_up", 10, 4'b0001, 4'b1001, 4'b1000, 4'b0000);

    // Bounce bit3 every 3 cycles for 40 cycles; no runs long enough to accept.
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      sw_in = (((c / 3) % 2) == 0) ? 4'b0001 : 4'b1001;
      tick();
      if (sw_changed || sw_db != 4'b1001) pulses++;
    end
    chk("bounce.quiet", 32'(pulses), 32'd0);
    sw_in = 4'b0001;
    expect_accept("bounce", 10, 4'b1001, 4'b0001, 4'b0000, 4'b1000);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (sw_changed) pulses++;
    end
    chk("bounce.after", 32'(pulses), 32'd0);

    // Get to sw_db=0100 (simultaneous rise bit2 / fall bit0).
    sw_in = 4'b0100;
    expect_accept("to0100", 10, 4'b0001, 4'b0100, 4'b0100, 4'b0001);

    // Simultaneous rise bit1 and fall bit2.
    sw_in = 4'b0010;
    expect_accept("simul", 10, 4'b0100, 4'b0010, 4'b0010, 4'b0100);

    // Async reset after 5 mismatch cycles on bit0.
    sw_in = 4'b0011;
    for (int k = 0; k < 7; k++) tick();
    chk_all("midcnt", 4'b0010, 4'b0, 4'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("arst", 4'b0000, 4'b0, 4'b0, 1'b0);
    #1 rst_n = 1'b1;
    expect_accept("restart", 10, 4'b0000, 4'b0011, 4'b0011, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
